// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the CDB arbiter slice: datapath widths, boolean
// constants, the packed {robnum, data} entry layout and a small wrap helper
// used by the round-robin pointer.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int Data_Len     = 32;
   localparam int Rob_Addr_Len = 4;
   localparam int Cdb_Req_Num  = 3;
   localparam int Entry_Len    = Rob_Addr_Len + Data_Len;

   localparam logic                True      = 1'b1;
   localparam logic                False     = 1'b0;
   localparam logic [Data_Len-1:0] Zero_Data = 32'h0000_0000;

   // Increment an index and wrap it back to zero at n (n need not be a power of two)
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/cdb_arbiter_req_fifo.sv
// -----------------------------------------------------------------------------
// cdb_req_fifo
// Small per-requester queue of {robnum, data} results waiting for a CDB slot.
// Ports:
//   clk     in   clock
//   rst_i   in   synchronous active-high reset
//   flush_i in   discard all queued entries (reset or misbranch)
//   push_i  in   write din_i at the tail (ignored when full)
//   pop_i   in   drop the head entry (ignored when empty)
//   din_i   in   entry to enqueue
//   head_o  out  entry at the head of the queue
//   full_o  out  occupancy equals DEPTH
//   empty_o out  occupancy is zero
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cdb_req_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [Entry_Len-1:0] din_i,
   output logic [Entry_Len-1:0] head_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [Entry_Len-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full_s, empty_s, do_push_s, do_pop_s;

   assign full_s  = (count_q == CW'(DEPTH));
   assign empty_s = (count_q == '0);
   assign full_o  = full_s;
   assign empty_o = empty_s;
   assign head_o  = mem_q[rd_ptr_q];

   // Next-state pointers and occupancy from the accepted push/pop pair
   always_comb begin
      do_push_s = push_i && !full_s;
      do_pop_s  = pop_i && !empty_s;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Tail write on an accepted push; storage itself needs no reset
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointer and occupancy registers, cleared by reset or flush
   always_ff @(posedge clk) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the two CDB broadcast ports between N_REQ functional-unit requesters.
// Each requester owns a cdb_req_fifo; a round-robin selector drains up to two
// heads per cycle into registered broadcast outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   has_misbranch       flush: drops queued results, resets the rr pointer
//   req_valid/ready     per-requester handshake (ready = FIFO not full)
//   req_robnum/data     packed per-requester tag (4b) and data (32b)
//   cdb_*_1 / cdb_*_2   registered broadcast ports
//   stat_grants/stalls  statistics counters (only with CDB_STATS_EN)
// Optional feature macro: CDB_STATS_EN adds the stat_* ports and counters.
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ      = Cdb_Req_Num,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           has_misbranch,
   input  logic [N_REQ-1:0]               req_valid,
   output logic [N_REQ-1:0]               req_ready,
   input  logic [N_REQ*Rob_Addr_Len-1:0]  req_robnum,
   input  logic [N_REQ*Data_Len-1:0]      req_data,
   output logic                           cdb_valid_1,
   output logic [Rob_Addr_Len-1:0]        cdb_robnum_1,
   output logic [Data_Len-1:0]            cdb_data_1,
   output logic                           cdb_valid_2,
   output logic [Rob_Addr_Len-1:0]        cdb_robnum_2,
   output logic [Data_Len-1:0]            cdb_data_2
`ifdef CDB_STATS_EN
   ,
   output logic [31:0]                    stat_grants,
   output logic [31:0]                    stat_stalls
`endif
);

   localparam int PW = $clog2(N_REQ);

   logic                 flush_s, advance_s;
   logic [N_REQ-1:0]     full_s, empty_s, push_s, pop_s, req_ready_s;
   logic [Entry_Len-1:0] head_s [N_REQ];

   logic                 g1_s, g2_s;
   logic [PW-1:0]        g1_idx_s, g2_idx_s, last_idx_s, idx_s;
   logic [PW:0]          sum_s;
   logic [Entry_Len-1:0] g1_entry_s, g2_entry_s;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

   logic                    valid_1_q, valid_2_q;
   logic [Rob_Addr_Len-1:0] robnum_1_q, robnum_2_q;
   logic [Data_Len-1:0]     data_1_q, data_2_q;

   // Queued results die on reset or misbranch; otherwise rdy gates all movement
   assign flush_s   = rst || has_misbranch;
   assign advance_s = rdy && !flush_s;

   // Requester handshake: ready reflects FIFO occupancy only, forced low when frozen or flushing
   always_comb begin
      if (advance_s) begin
         req_ready_s = ~full_s;
      end else begin
         req_ready_s = '0;
      end
   end
   assign req_ready = req_ready_s;
   assign push_s    = req_valid & req_ready_s;

   for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
      cdb_req_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_i   (rst),
         .flush_i (has_misbranch),
         .push_i  (push_s[i]),
         .pop_i   (pop_s[i]),
         .din_i   ({req_robnum[Rob_Addr_Len*i +: Rob_Addr_Len], req_data[Data_Len*i +: Data_Len]}),
         .head_o  (head_s[i]),
         .full_o  (full_s[i]),
         .empty_o (empty_s[i])
      );
      // A FIFO pops when either port picked it and the edge actually advances
      assign pop_s[i] = advance_s && ((g1_s && (g1_idx_s == PW'(i))) || (g2_s && (g2_idx_s == PW'(i))));
   end

   // Round-robin scan from rr_ptr: first non-empty FIFO wins port 1, second wins port 2
   always_comb begin
      g1_s       = False;
      g2_s       = False;
      g1_idx_s   = '0;
      g2_idx_s   = '0;
      g1_entry_s = '0;
      g2_entry_s = '0;
      sum_s      = '0;
      idx_s      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (sum_s >= (PW+1)'(N_REQ)) begin
            sum_s = sum_s - (PW+1)'(N_REQ);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[PW-1:0];
         if (!empty_s[idx_s] && !g1_s) begin
            g1_s       = True;
            g1_idx_s   = idx_s;
            g1_entry_s = head_s[idx_s];
         end else if (!empty_s[idx_s] && !g2_s) begin
            g2_s       = True;
            g2_idx_s   = idx_s;
            g2_entry_s = head_s[idx_s];
         end else begin
            g2_s = g2_s;
         end
      end
   end

   // Pointer moves past the last granted requester; holds when nothing was granted
   always_comb begin
      if (g2_s) begin
         last_idx_s = g2_idx_s;
      end else begin
         last_idx_s = g1_idx_s;
      end
      if (g1_s) begin
         rr_ptr_d = PW'(wrap_inc(32'(last_idx_s), N_REQ));
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Broadcast registers and rr pointer; an idle port drops valid but keeps tag/data
   always_ff @(posedge clk) begin
      if (flush_s) begin
         rr_ptr_q   <= '0;
         valid_1_q  <= False;
         valid_2_q  <= False;
         robnum_1_q <= '0;
         robnum_2_q <= '0;
         data_1_q   <= Zero_Data;
         data_2_q   <= Zero_Data;
      end else if (rdy) begin
         rr_ptr_q  <= rr_ptr_d;
         valid_1_q <= g1_s;
         valid_2_q <= g2_s;
         if (g1_s) begin
            robnum_1_q <= g1_entry_s[Entry_Len-1 -: Rob_Addr_Len];
            data_1_q   <= g1_entry_s[Data_Len-1:0];
         end
         if (g2_s) begin
            robnum_2_q <= g2_entry_s[Entry_Len-1 -: Rob_Addr_Len];
            data_2_q   <= g2_entry_s[Data_Len-1:0];
         end
      end
   end

   assign cdb_valid_1  = valid_1_q;
   assign cdb_robnum_1 = robnum_1_q;
   assign cdb_data_1   = data_1_q;
   assign cdb_valid_2  = valid_2_q;
   assign cdb_robnum_2 = robnum_2_q;
   assign cdb_data_2   = data_2_q;

`ifdef CDB_STATS_EN
   logic [31:0] stat_grants_q, stat_stalls_q, stall_cnt_s;
   logic [1:0]  grant_cnt_s;

   // Per-edge increments: broadcasts issued and requesters left waiting
   always_comb begin
      grant_cnt_s = {1'b0, g1_s} + {1'b0, g2_s};
      stall_cnt_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         stall_cnt_s = stall_cnt_s + 32'(req_valid[i] && !req_ready_s[i]);
      end
   end

   // Statistics survive misbranch; only reset clears them, and they wrap freely
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants_q <= '0;
         stat_stalls_q <= '0;
      end else if (rdy) begin
         if (!has_misbranch) begin
            stat_grants_q <= stat_grants_q + 32'(grant_cnt_s);
         end
         stat_stalls_q <= stat_stalls_q + stall_cnt_s;
      end
   end

   assign stat_grants = stat_grants_q;
   assign stat_stalls = stat_stalls_q;
`endif

endmodule
